// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter
// Shares one multi-cycle bfloat16 divider among N_REQ requesters. Requests
// are granted round-robin, the winner's operands are registered and the
// divider is started with a one-cycle pulse. The divider result and flags
// come back on a single response channel tagged with the owner id.
//
// Optional build: define FPDIV_ARB_TIMEOUT_EN to add a watchdog on the WAIT
// state and the rsp_timeout output. A stuck divider then produces a qNaN
// response with rsp_timeout=1 after TIMEOUT_CYCLES cycles in WAIT.
//
// state   | meaning
// S_IDLE  | arbitrate; req_ready is the one-hot grant, handshake latches operands
// S_ISSUE | div_start high for this single cycle
// S_WAIT  | wait for div_valid (or watchdog expiry when enabled)
// S_RESP  | hold response until rsp_ready, then advance rr pointer

module fp_div_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ID_W           = $clog2(N_REQ),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [16*N_REQ-1:0]   req_opA,
  input  logic [16*N_REQ-1:0]   req_opB,

  output logic                  div_start,
  output logic [15:0]           div_opA,
  output logic [15:0]           div_opB,
  input  logic                  div_valid,
  input  logic                  div_busy,
  input  logic [15:0]           div_quotient,
  input  logic                  div_underflow,
  input  logic                  div_overflow,
  input  logic                  div_inexact,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_quotient,
`ifdef FPDIV_ARB_TIMEOUT_EN
  output logic                  rsp_timeout,
`endif
  output logic                  rsp_underflow,
  output logic                  rsp_overflow,
  output logic                  rsp_inexact
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // qNaN returned when the watchdog aborts an operation
  localparam logic [15:0] QNAN = 16'h7FC0;

  // Reject parameter values the round-robin scan and watchdog cannot handle
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("fp_div_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   owner;

  logic              grant_any;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W:0]     scan_idx;
  logic [15:0]       sel_opA;
  logic [15:0]       sel_opB;

  // Busy is informational only; the FSM tracks the operation itself.
  logic              unused_busy;
  assign unused_busy = div_busy;

`ifdef FPDIV_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]   wd_cnt;
`endif

  // Round-robin search: first valid requester at or above rr_ptr, wrapping
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(N_REQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(N_REQ);
      end
      if (!grant_any && req_valid[scan_idx[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = scan_idx[ID_W-1:0];
      end
    end
  end

  assign sel_opA = req_opA[16*grant_id +: 16];
  assign sel_opB = req_opB[16*grant_id +: 16];

  // Grant is offered only in IDLE and never while reset is asserted
  always_comb begin
    req_ready = '0;
    if (reset && state == S_IDLE && grant_any) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Arbiter FSM with registered divider and response outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      div_start     <= 1'b0;
      div_opA       <= '0;
      div_opB       <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_underflow <= 1'b0;
      rsp_overflow  <= 1'b0;
      rsp_inexact   <= 1'b0;
`ifdef FPDIV_ARB_TIMEOUT_EN
      rsp_timeout   <= 1'b0;
      wd_cnt        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            div_opA   <= sel_opA;
            div_opB   <= sel_opB;
            owner     <= grant_id;
            div_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          div_start <= 1'b0;
          state     <= S_WAIT;
`ifdef FPDIV_ARB_TIMEOUT_EN
          // Down-counter reaches zero on the last allowed WAIT cycle
          wd_cnt    <= WD_W'(TIMEOUT_CYCLES - 1);
`endif
        end

        S_WAIT: begin
          if (div_valid) begin
            rsp_valid     <= 1'b1;
            rsp_id        <= owner;
            rsp_quotient  <= div_quotient;
            rsp_underflow <= div_underflow;
            rsp_overflow  <= div_overflow;
            rsp_inexact   <= div_inexact;
`ifdef FPDIV_ARB_TIMEOUT_EN
            rsp_timeout   <= 1'b0;
`endif
            state         <= S_RESP;
          end
`ifdef FPDIV_ARB_TIMEOUT_EN
          else if (wd_cnt == '0) begin
            rsp_valid     <= 1'b1;
            rsp_id        <= owner;
            rsp_quotient  <= QNAN;
            rsp_underflow <= 1'b0;
            rsp_overflow  <= 1'b0;
            rsp_inexact   <= 1'b0;
            rsp_timeout   <= 1'b1;
            state         <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
`endif
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter
// Randomized and directed stimulus around fp_div_arbiter with a behavioural
// bfloat16 divider. A transaction-level model predicts grants, start pulses
// and responses each cycle. Define FPDIV_ARB_TIMEOUT_EN to cover the watchdog.

module tb_fp_div_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 64;
`ifdef FPDIV_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_opA = '0;
  logic [16*N-1:0] req_opB = '0;
  logic            div_start;
  logic [15:0]     div_opA, div_opB;
  logic            div_valid = 1'b0;
  logic            div_busy = 1'b0;
  logic [15:0]     div_quotient = '0;
  logic            div_underflow = 1'b0, div_overflow = 1'b0, div_inexact = 1'b0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [IDW-1:0]  rsp_id;
  logic [15:0]     rsp_quotient;
  logic            rsp_underflow, rsp_overflow, rsp_inexact;
`ifdef FPDIV_ARB_TIMEOUT_EN
  logic            rsp_timeout;
`endif

  fp_div_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opA(req_opA), .req_opB(req_opB),
    .div_start(div_start), .div_opA(div_opA), .div_opB(div_opB),
    .div_valid(div_valid), .div_busy(div_busy), .div_quotient(div_quotient),
    .div_underflow(div_underflow), .div_overflow(div_overflow), .div_inexact(div_inexact),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient),
`ifdef FPDIV_ARB_TIMEOUT_EN
    .rsp_timeout(rsp_timeout),
`endif
    .rsp_underflow(rsp_underflow), .rsp_overflow(rsp_overflow), .rsp_inexact(rsp_inexact)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h cycle=%0d", tag, got, want, cyc);
    end
  endtask

  // bfloat16 divide, truncating; returns {underflow, overflow, inexact, quotient}
  function automatic logic [18:0] bdiv(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, e, ma, mb, q, r;
    logic s, ix;
    logic [6:0] m;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    ma = 128 + int'(a[6:0]);
    mb = 128 + int'(b[6:0]);
    q  = (ma * 256) / mb;
    r  = (ma * 256) % mb;
    e  = ea - eb + 127;
    if (q >= 256) begin
      m  = q[7:1];
      ix = (r != 0) || q[0];
    end else begin
      m  = q[6:0];
      e  = e - 1;
      ix = (r != 0);
    end
    if (e >= 255) return {1'b0, 1'b1, 1'b1, s, 8'hFF, 7'h00};
    if (e <= 0)   return {1'b1, 1'b0, 1'b1, s, 15'h0000};
    return {1'b0, 1'b0, ix, s, e[7:0], m};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [15:0] rand_op();
    logic [7:0] e;
    e = 8'($urandom_range(110, 145));
    return {1'($urandom), e, 7'($urandom)};
  endfunction

  // ---------------- behavioural divider ----------------
  int   div_lat = 10;
  bit   rand_lat = 1'b0;
  bit   div_mute = 1'b0;
  bit   stale_force = 1'b0;
  int   dcnt = 0;
  logic [15:0] d_a = '0, d_b = '0;

  initial begin
    forever begin
      bit fire;
      logic [18:0] res;
      @(posedge clk);
      #2;
      fire = 1'b0;
      if (div_start && !div_mute) begin
        dcnt = rand_lat ? $urandom_range(1, 12) : div_lat;
        d_a  = div_opA;
        d_b  = div_opB;
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) fire = 1'b1;
      end
      div_busy  = (dcnt > 0);
      div_valid = fire | stale_force;
      if (fire) begin
        res = bdiv(d_a, d_b);
        {div_underflow, div_overflow, div_inexact, div_quotient} = res;
      end else begin
        div_quotient  = 16'($urandom);
        div_underflow = 1'($urandom);
        div_overflow  = 1'($urandom);
        div_inexact   = 1'($urandom);
      end
    end
  end

  // ---------------- reference model / monitor ----------------
  bit          m_busy = 1'b0, m_start = 1'b0, m_rsp = 1'b0, m_to = 1'b0;
  int          m_wait = -1;
  int          m_rr = 0;
  int          cur_id = 0;
  logic [15:0] cur_a = '0, cur_b = '0;
  logic [15:0] e_q = '0;
  logic [2:0]  e_f = '0;
  logic [N-1:0] hs_vec = '0;
  int          glog[$];

  initial begin
    forever begin
      int g;
      logic [N-1:0] exp_ready;
      logic [18:0] res;
      @(negedge clk);
      g = (m_busy || !reset) ? -1 : rr_pick(req_valid, m_rr);
      exp_ready = (g < 0) ? '0 : (N'(1) << g);
      check_val("req_ready", 32'(req_ready), 32'(exp_ready));
      check_val("div_start", 32'(div_start), 32'(m_start));
      if (m_start) begin
        check_val("div_opA", 32'(div_opA), 32'(cur_a));
        check_val("div_opB", 32'(div_opB), 32'(cur_b));
      end
      check_val("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
      if (m_rsp) begin
        check_val("rsp_id", 32'(rsp_id), 32'(cur_id));
        check_val("rsp_quotient", 32'(rsp_quotient), 32'(e_q));
        check_val("rsp_flags", 32'({rsp_underflow, rsp_overflow, rsp_inexact}), 32'(e_f));
`ifdef FPDIV_ARB_TIMEOUT_EN
        check_val("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
`endif
      end
      hs_vec = req_valid & req_ready;

      if (!reset) begin
        m_busy = 1'b0; m_start = 1'b0; m_rsp = 1'b0; m_to = 1'b0;
        m_wait = -1; m_rr = 0;
      end else if (m_rsp) begin
        if (rsp_ready) begin
          m_rsp  = 1'b0;
          m_busy = 1'b0;
          m_rr   = (cur_id + 1) % N;
        end
      end else if (m_wait >= 0) begin
        if (div_valid) begin
          res  = bdiv(cur_a, cur_b);
          e_f  = res[18:16];
          e_q  = res[15:0];
          m_to = 1'b0; m_rsp = 1'b1; m_wait = -1;
        end else if (TO_EN && m_wait == TO - 1) begin
          e_f  = '0;
          e_q  = 16'h7FC0;
          m_to = 1'b1; m_rsp = 1'b1; m_wait = -1;
        end else begin
          m_wait++;
        end
      end else if (m_start) begin
        m_start = 1'b0;
        m_wait  = 0;
      end else if (g >= 0) begin
        m_busy  = 1'b1;
        m_start = 1'b1;
        cur_id  = g;
        cur_a   = req_opA[16*g +: 16];
        cur_b   = req_opB[16*g +: 16];
        glog.push_back(g);
      end
    end
  end

  // ---------------- requester / response driver ----------------
  int drv_mode = 0;  // 0 manual, 1 all valid, 2 random
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 stalled

  task automatic new_req(input int i);
    req_valid[i] = 1'b1;
    req_opA[16*i +: 16] = rand_op();
    req_opB[16*i +: 16] = rand_op();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = ($urandom_range(0, 2) != 0);
        default: rsp_ready = 1'b0;
      endcase
      if (drv_mode == 1) begin
        for (int i = 0; i < N; i++) begin
          if (hs_vec[i] || !req_valid[i]) new_req(i);
        end
      end else if (drv_mode == 2) begin
        for (int i = 0; i < N; i++) begin
          if (hs_vec[i]) begin
            if ($urandom_range(0, 1) == 1) new_req(i);
            else req_valid[i] = 1'b0;
          end else if (req_valid[i]) begin
            if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
          end else if ($urandom_range(0, 2) == 0) begin
            new_req(i);
          end
        end
      end
    end
  end

  // ---------------- sequence helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_req_ready"}, 32'(req_ready), 32'h0);
    check_val({pfx, "_div_start"}, 32'(div_start), 32'h0);
    check_val({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check_val({pfx, "_div_ops"}, {div_opA, div_opB}, 32'h0);
    check_val({pfx, "_rsp_id"}, 32'(rsp_id), 32'h0);
    check_val({pfx, "_rsp_q"}, 32'(rsp_quotient), 32'h0);
    check_val({pfx, "_rsp_flags"}, 32'({rsp_underflow, rsp_overflow, rsp_inexact}), 32'h0);
`ifdef FPDIV_ARB_TIMEOUT_EN
    check_val({pfx, "_rsp_timeout"}, 32'(rsp_timeout), 32'h0);
`endif
  endtask

  // wait (bounded) for a handshake on requester i; returns its cycle
  task automatic wait_hs(input int i, input string tag, output int t);
    bit ok;
    ok = 1'b0;
    t  = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      sample();
      if (hs_vec[i]) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
    check_val(tag, 32'(ok), 32'h1);
  endtask

  task automatic wait_rsp(input int limit, input string tag, output int t);
    bit ok;
    ok = 1'b0;
    t  = 0;
    for (int k = 0; k < limit && !ok; k++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        t  = cyc;
      end else begin
        sample();
      end
    end
    check_val(tag, 32'(ok), 32'h1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      sample();
      if (!m_busy) ok = 1'b1;
    end
    check_val(tag, 32'(ok), 32'h1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t_hs, t_rsp;
    logic [18:0] res;

    // Reset: requests present must still see req_ready=0
    reset = 1'b0;
    req_valid = '1;
    step(3);
    sample();
    check_reset_outputs("rst");
    step(1);
    req_valid = '0;

    // Stale divider valid right after reset release, no request
    reset = 1'b1;
    stale_force = 1'b1;
    step(2);
    stale_force = 1'b0;
    step(3);
    sample();
    check_val("stale_rsp_valid", 32'(rsp_valid), 32'h0);

    // Single request: 1.0 / 2.0
    step(1);
    req_valid[0] = 1'b1;
    req_opA[15:0] = 16'h3F80;
    req_opB[15:0] = 16'h4000;
    wait_hs(0, "single_hs", t_hs);
    step(1);
    req_valid[0] = 1'b0;
    sample();
    check_val("single_start_t1", 32'(div_start), 32'h1);
    check_val("single_start_cyc", 32'(cyc), 32'(t_hs + 1));
    sample();
    check_val("single_start_pulse", 32'(div_start), 32'h0);
    wait_rsp(40, "single_rsp_seen", t_rsp);
    check_val("single_rsp_latency", 32'(t_rsp), 32'(t_hs + 12));
    check_val("single_rsp_id", 32'(rsp_id), 32'h0);
    check_val("single_rsp_q", 32'(rsp_quotient), 32'h3F00);
    check_val("single_rsp_flags", 32'({rsp_underflow, rsp_overflow, rsp_inexact}), 32'h0);
    wait_idle("single_idle");

    // All requesters continuously valid from reset: order 0,1,2,3,0,1
    step(1);
    reset = 1'b0;
    drv_mode = 1;
    step(2);
    glog.delete();
    reset = 1'b1;
    for (int k = 0; k < 400 && glog.size() < 6; k++) sample();
    check_val("rr_count", 32'(glog.size() >= 6), 32'h1);
    for (int k = 0; k < 6 && k < glog.size(); k++) begin
      check_val($sformatf("rr_grant%0d", k), 32'(glog[k]), 32'(k % N));
    end
    drv_mode = 0;
    step(1);
    req_valid = '0;
    wait_idle("rr_idle");

    // Response backpressure
    step(1);
    rdy_mode = 2;
    new_req(1);
    res = bdiv(req_opA[31:16], req_opB[31:16]);
    wait_hs(1, "bp_hs", t_hs);
    step(1);
    req_valid[1] = 1'b0;
    req_valid[2] = 1'b1;
    req_valid[3] = 1'b1;
    sample();
    wait_rsp(40, "bp_rsp_seen", t_rsp);
    for (int k = 0; k < 5; k++) begin
      check_val("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check_val("bp_rsp_id", 32'(rsp_id), 32'h1);
      check_val("bp_rsp_q", 32'(rsp_quotient), 32'(res[15:0]));
      check_val("bp_req_ready", 32'(req_ready), 32'h0);
      sample();
    end
    step(1);
    rdy_mode = 0;
    req_valid = '0;
    wait_idle("bp_idle");

    // Randomized traffic with random divider latency and backpressure
    rand_lat = 1'b1;
    drv_mode = 2;
    rdy_mode = 1;
    step(1500);
    drv_mode = 0;
    rdy_mode = 0;
    req_valid = '0;
    wait_idle("rand_idle");
    rand_lat = 1'b0;

    // Reset while in WAIT aborts the operation
    step(1);
    new_req(2);
    wait_hs(2, "rw_hs", t_hs);
    step(1);
    req_valid[2] = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    sample();
    check_reset_outputs("rw");
    step(1);
    reset = 1'b1;
    step(20);
    sample();
    check_val("rw_no_rsp", 32'(rsp_valid), 32'h0);

    // Divider never answers
    div_mute = 1'b1;
    step(1);
    new_req(3);
    wait_hs(3, "wd_hs", t_hs);
    step(1);
    req_valid[3] = 1'b0;
`ifdef FPDIV_ARB_TIMEOUT_EN
    wait_rsp(200, "wd_rsp_seen", t_rsp);
    check_val("wd_latency", 32'(t_rsp - (t_hs + 2)), 32'(TO));
    check_val("wd_timeout", 32'(rsp_timeout), 32'h1);
    check_val("wd_q", 32'(rsp_quotient), 32'h7FC0);
    check_val("wd_id", 32'(rsp_id), 32'h3);
    wait_idle("wd_idle");
`else
    step(100);
    sample();
    check_val("wd_still_wait", 32'(rsp_valid), 32'h0);
    check_val("wd_no_grant", 32'(req_ready), 32'h0);
    step(1);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
`endif
    div_mute = 1'b0;
    step(5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard stop in case a sequence step stalls
  initial begin
    #2000000;
    $display("FAIL global_timeout: got=stalled want=finished");
    $fatal(1, "global timeout");
  end

endmodule
